axi_wr_monitor: RTL and testbench

- Passive checker that sits directly downstream of the AXI write-side protocol FSM. It consumes that FSM's AW/W/B channel outputs and drives nothing back onto the bus.
- Tracks outstanding write bursts in a small queue, counts W beats against each accepted awlen, and checks WLAST placement, VALID/payload stability and B ordering.
- Reports sticky error flags, a per-burst completion pulse and running counters to the formal/simulation harness.

---
 rtl/axi_mon_pkg.sv | 23 ++
 rtl/axi_mon_fifo.sv | 47 ++++
 rtl/axi_wr_monitor.sv | 164 ++++++++++++++++
 tb/tb_axi_wr_monitor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mon_pkg.sv
// Shared types and constants for the AXI write-channel monitor.
package axi_mon_pkg;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    // Queue entries carry addresses up to this width.
    localparam int MON_AW = 32;

    typedef enum logic {
        ST_IDLE,
        ST_STALL
    } stab_state_t;

    typedef struct packed {
        logic [MON_AW-1:0] addr;
        logic [7:0]        len;
    } aw_entry_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_mon_fifo.sv
// Synchronous FIFO holding accepted AW entries; supports push and pop in the same cycle.
module axi_mon_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/axi_wr_monitor.sv
// Passive AXI write-side checker: burst tracking, WLAST/B ordering and VALID stability flags.
module axi_wr_monitor
    import axi_mon_pkg::*;
#(
    parameter int AW    = MON_AW,
    parameter int DEPTH = 4,
    parameter int CW    = 16,
    localparam int OW   = $clog2(DEPTH) + 1
) (
    input  logic          axi_aclk,
    input  logic          rst,
    input  logic [AW-1:0] axi_awaddr,
    input  logic [7:0]    axi_awlen,
    input  logic [2:0]    axi_awsize,
    input  logic [1:0]    axi_awburst,
    input  logic          axi_awvalid,
    input  logic          axi_awready,
    input  logic [63:0]   axi_wdata,
    input  logic [7:0]    axi_wstrb,
    input  logic          axi_wlast,
    input  logic          axi_wvalid,
    input  logic          axi_wready,
    input  logic [1:0]    axi_bresp,
    input  logic          axi_bvalid,
    input  logic          axi_bready,
    output logic          burst_done,
    output logic [AW-1:0] burst_addr,
    output logic [8:0]    burst_beats,
    output logic [CW-1:0] wr_burst_cnt,
    output logic [OW-1:0] outstanding,
    output logic          err_aw_stable,
    output logic          err_w_stable,
    output logic          err_b_stable,
    output logic          err_wlast,
    output logic          err_w_no_aw,
    output logic          err_b_early,
    output logic          err_bresp,
    output logic          err_overflow,
    output logic          err_any
);

    localparam int EW = $bits(aw_entry_t);
    localparam int PW = max_int(AW + 13, 73);

    logic aw_hs, w_hs, b_hs;
    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid  & axi_wready;
    assign b_hs  = axi_bvalid  & axi_bready;

    aw_entry_t     in_e, head_e, cur_e;
    logic [EW-1:0] head_raw;
    logic          q_full, q_empty, push, pop;
    logic [7:0]    wcnt;
    logic [7:0]    b_pending;

    assign in_e   = '{addr: MON_AW'(axi_awaddr), len: axi_awlen};
    assign head_e = aw_entry_t'(head_raw);

    // An empty queue lets a same-cycle AW serve the W beat directly.
    logic bypass, beat_ok, beat_last, close, b_early, b_take;
    assign bypass    = q_empty & aw_hs;
    assign cur_e     = q_empty ? in_e : head_e;
    assign beat_ok   = w_hs & (~q_empty | aw_hs);
    assign beat_last = (wcnt == cur_e.len);
    assign close     = beat_ok & beat_last;
    assign pop       = close & ~q_empty;
    assign push      = aw_hs & ~(bypass & close) & (~q_full | pop);
    assign b_early   = b_hs & (b_pending == '0) & ~close;
    assign b_take    = b_hs & ~b_early;

    axi_mon_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (axi_aclk),
        .rst   (rst),
        .push  (push),
        .din   (in_e),
        .pop   (pop),
        .head  (head_raw),
        .full  (q_full),
        .empty (q_empty),
        .count (outstanding)
    );

    always_ff @(posedge axi_aclk) begin
        if (!rst) begin
            wcnt         <= '0;
            b_pending    <= '0;
            burst_done   <= 1'b0;
            burst_addr   <= '0;
            burst_beats  <= '0;
            wr_burst_cnt <= '0;
            err_wlast    <= 1'b0;
            err_w_no_aw  <= 1'b0;
            err_b_early  <= 1'b0;
            err_bresp    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            burst_done <= close;
            if (beat_ok) wcnt <= beat_last ? 8'd0 : wcnt + 8'd1;
            if (close) begin
                burst_addr  <= AW'(cur_e.addr);
                burst_beats <= {1'b0, cur_e.len} + 9'd1;
            end
            case ({close, b_take})
                2'b10:   b_pending <= b_pending + 8'd1;
                2'b01:   b_pending <= b_pending - 8'd1;
                default: ;
            endcase
            if (b_take) wr_burst_cnt <= wr_burst_cnt + CW'(1);
            err_wlast    <= err_wlast    | (beat_ok & (axi_wlast != beat_last));
            err_w_no_aw  <= err_w_no_aw  | (w_hs & q_empty & ~aw_hs);
            err_b_early  <= err_b_early  | b_early;
            err_bresp    <= err_bresp    | (b_hs & (axi_bresp != BRESP_OKAY));
            err_overflow <= err_overflow | (aw_hs & q_full & ~pop);
        end
    end

    // Channel 0 = AW, 1 = W, 2 = B; payloads zero-extended to a common width.
    logic [PW-1:0] pay [3];
    logic [2:0]    ch_valid, ch_ready, err_stab;

    assign pay[0]   = PW'({axi_awaddr, axi_awlen, axi_awsize, axi_awburst});
    assign pay[1]   = PW'({axi_wdata, axi_wstrb, axi_wlast});
    assign pay[2]   = PW'(axi_bresp);
    assign ch_valid = {axi_bvalid, axi_wvalid, axi_awvalid};
    assign ch_ready = {axi_bready, axi_wready, axi_awready};

    for (genvar g = 0; g < 3; g++) begin : g_stab
        stab_state_t   state;
        logic [PW-1:0] cap;
        logic          err;

        always_ff @(posedge axi_aclk) begin
            if (!rst) begin
                state <= ST_IDLE;
                cap   <= '0;
                err   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ch_valid[g] && !ch_ready[g]) begin
                            state <= ST_STALL;
                            cap   <= pay[g];
                        end
                    end
                    ST_STALL: begin
                        if (!ch_valid[g] || pay[g] != cap) err <= 1'b1;
                        if (!ch_valid[g] || ch_ready[g]) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign err_stab[g] = err;
    end

    assign err_aw_stable = err_stab[0];
    assign err_w_stable  = err_stab[1];
    assign err_b_stable  = err_stab[2];

    assign err_any = err_aw_stable | err_w_stable | err_b_stable | err_wlast
                   | err_w_no_aw | err_b_early | err_bresp | err_overflow;

endmodule

// File: tb/tb_axi_wr_monitor.sv
// Directed bench for axi_wr_monitor: a vector table for the basic burst flow plus corner-case sequences.
module tb_axi_wr_monitor;

    logic        axi_aclk = 1'b0;
    logic        rst;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid, axi_awready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast, axi_wvalid, axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid, axi_bready;
    logic        burst_done;
    logic [31:0] burst_addr;
    logic [8:0]  burst_beats;
    logic [15:0] wr_burst_cnt;
    logic [2:0]  outstanding;
    logic        err_aw_stable, err_w_stable, err_b_stable, err_wlast, err_w_no_aw;
    logic        err_b_early, err_bresp, err_overflow, err_any;

    int n_checks = 0;
    int n_errors = 0;

    always #5 axi_aclk = ~axi_aclk;

    axi_wr_monitor #(.AW(32), .DEPTH(4), .CW(16)) dut (
        .axi_aclk     (axi_aclk),
        .rst          (rst),
        .axi_awaddr   (axi_awaddr),
        .axi_awlen    (axi_awlen),
        .axi_awsize   (axi_awsize),
        .axi_awburst  (axi_awburst),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_wlast    (axi_wlast),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready),
        .burst_done   (burst_done),
        .burst_addr   (burst_addr),
        .burst_beats  (burst_beats),
        .wr_burst_cnt (wr_burst_cnt),
        .outstanding  (outstanding),
        .err_aw_stable(err_aw_stable),
        .err_w_stable (err_w_stable),
        .err_b_stable (err_b_stable),
        .err_wlast    (err_wlast),
        .err_w_no_aw  (err_w_no_aw),
        .err_b_early  (err_b_early),
        .err_bresp    (err_bresp),
        .err_overflow (err_overflow),
        .err_any      (err_any)
    );

    typedef struct {
        logic        awv;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        wv;
        logic        wlast;
        logic        bv;
        logic [1:0]  bresp;
        logic        e_done;
        logic [31:0] e_addr;
        logic [8:0]  e_beats;
        logic [15:0] e_cnt;
        logic [2:0]  e_out;
        logic        e_any;
    } vec_t;

    vec_t tv [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic idle();
        axi_awvalid = 1'b0; axi_awready = 1'b1;
        axi_wvalid  = 1'b0; axi_wready  = 1'b1; axi_wlast = 1'b0;
        axi_bvalid  = 1'b0; axi_bready  = 1'b1; axi_bresp = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic set_aw(input logic v, input logic [31:0] a, input logic [7:0] l);
        axi_awvalid = v; axi_awaddr = a; axi_awlen = l;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axi_awaddr = '0; axi_awlen = '0; axi_awsize = 3'd3; axi_awburst = 2'b01;
        axi_wdata = 64'hDEAD_BEEF_0123_4567; axi_wstrb = 8'hFF;
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        check("reset burst_done", burst_done, 0);
        check("reset burst_addr", burst_addr, 0);
        check("reset burst_beats", burst_beats, 0);
        check("reset wr_burst_cnt", wr_burst_cnt, 0);
        check("reset outstanding", outstanding, 0);
        check("reset err_any", err_any, 0);

        //        awv  addr        len   wv wl bv bresp  done e_addr      beats cnt  out any
        tv[0]  = '{1, 32'h100, 3, 0, 0, 0, 2'b00, 0, 32'h000, 0, 0, 1, 0};
        tv[1]  = '{0, 32'h000, 0, 1, 0, 0, 2'b00, 0, 32'h000, 0, 0, 1, 0};
        tv[2]  = '{0, 32'h000, 0, 1, 0, 0, 2'b00, 0, 32'h000, 0, 0, 1, 0};
        tv[3]  = '{0, 32'h000, 0, 1, 0, 0, 2'b00, 0, 32'h000, 0, 0, 1, 0};
        tv[4]  = '{0, 32'h000, 0, 1, 1, 0, 2'b00, 1, 32'h100, 4, 0, 0, 0};
        tv[5]  = '{0, 32'h000, 0, 0, 0, 1, 2'b00, 0, 32'h100, 4, 1, 0, 0};
        tv[6]  = '{0, 32'h000, 0, 0, 0, 0, 2'b00, 0, 32'h100, 4, 1, 0, 0};
        tv[7]  = '{1, 32'h200, 1, 0, 0, 0, 2'b00, 0, 32'h100, 4, 1, 1, 0};
        tv[8]  = '{0, 32'h000, 0, 1, 1, 0, 2'b00, 0, 32'h100, 4, 1, 1, 1};
        tv[9]  = '{0, 32'h000, 0, 1, 1, 0, 2'b00, 1, 32'h200, 2, 1, 0, 1};
        tv[10] = '{0, 32'h000, 0, 0, 0, 1, 2'b00, 0, 32'h200, 2, 2, 0, 1};
        tv[11] = '{1, 32'h240, 0, 1, 1, 0, 2'b00, 1, 32'h240, 1, 2, 0, 1};
        tv[12] = '{0, 32'h000, 0, 0, 0, 1, 2'b00, 0, 32'h240, 1, 3, 0, 1};

        for (int i = 0; i < 13; i++) begin
            set_aw(tv[i].awv, tv[i].addr, tv[i].len);
            axi_wvalid = tv[i].wv; axi_wlast = tv[i].wlast;
            axi_bvalid = tv[i].bv; axi_bresp = tv[i].bresp;
            tick();
            check($sformatf("v%0d burst_done", i), burst_done, tv[i].e_done);
            check($sformatf("v%0d burst_addr", i), burst_addr, tv[i].e_addr);
            check($sformatf("v%0d burst_beats", i), burst_beats, tv[i].e_beats);
            check($sformatf("v%0d wr_burst_cnt", i), wr_burst_cnt, tv[i].e_cnt);
            check($sformatf("v%0d outstanding", i), outstanding, tv[i].e_out);
            check($sformatf("v%0d err_any", i), err_any, tv[i].e_any);
        end
        idle();
        check("table err_wlast sticky", err_wlast, 1);
        check("table err_w_no_aw", err_w_no_aw, 0);
        check("table err_b_early", err_b_early, 0);

        // Overflow: four AWs fill the queue, the fifth is dropped.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_aw(1'b1, 32'h1000 + 32'(i) * 32'h10, 8'd0);
            tick();
            if (i == 3) begin
                check("ovf outstanding at 4", outstanding, 4);
                check("ovf not yet", err_overflow, 0);
            end
        end
        check("ovf outstanding capped", outstanding, 4);
        check("ovf err_overflow", err_overflow, 1);
        set_aw(1'b1, 32'h2000, 8'd0);
        axi_wvalid = 1'b1; axi_wlast = 1'b1;
        tick();
        idle();
        check("full push+pop outstanding", outstanding, 4);
        check("full push+pop burst_done", burst_done, 1);
        check("full push+pop burst_addr", burst_addr, 32'h1000);
        check("full push+pop err_wlast", err_wlast, 0);
        check("full push+pop err_w_no_aw", err_w_no_aw, 0);

        // AW payload changes while stalled.
        do_reset();
        axi_awready = 1'b0;
        set_aw(1'b1, 32'h500, 8'd0); tick();
        set_aw(1'b1, 32'h504, 8'd0); tick();
        tick();
        idle();
        check("aw addr change err_aw_stable", err_aw_stable, 1);

        // Same stall with a constant payload, then accepted.
        do_reset();
        axi_awready = 1'b0;
        set_aw(1'b1, 32'h500, 8'd0);
        tick(); tick(); tick();
        axi_awready = 1'b1;
        tick();
        idle();
        check("aw steady err_aw_stable", err_aw_stable, 0);
        check("aw steady outstanding", outstanding, 1);
        check("aw steady err_any", err_any, 0);
        axi_wready = 1'b0; axi_wvalid = 1'b1; axi_wlast = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        tick();
        check("w valid drop err_w_stable", err_w_stable, 1);
        idle();
        axi_bready = 1'b0; axi_bvalid = 1'b1; axi_bresp = 2'b00;
        tick();
        axi_bresp = 2'b10;
        tick();
        idle();
        check("b resp change err_b_stable", err_b_stable, 1);
        check("b stall err_b_early", err_b_early, 0);
        check("b stall err_bresp", err_bresp, 0);

        // Bypass of a same-cycle AW, bad response, early B.
        do_reset();
        set_aw(1'b1, 32'h300, 8'd0);
        axi_wvalid = 1'b1; axi_wlast = 1'b1;
        tick();
        idle();
        check("bypass err_w_no_aw", err_w_no_aw, 0);
        check("bypass burst_done", burst_done, 1);
        check("bypass burst_beats", burst_beats, 1);
        check("bypass burst_addr", burst_addr, 32'h300);
        check("bypass outstanding", outstanding, 0);
        axi_bvalid = 1'b1; axi_bresp = 2'b10;
        tick();
        idle();
        check("slverr wr_burst_cnt", wr_burst_cnt, 1);
        check("slverr err_bresp", err_bresp, 1);
        check("slverr err_b_early", err_b_early, 0);
        axi_bvalid = 1'b1;
        tick();
        idle();
        check("extra B err_b_early", err_b_early, 1);
        check("extra B wr_burst_cnt", wr_burst_cnt, 1);

        // Final W beat and B handshake in the same cycle.
        do_reset();
        set_aw(1'b1, 32'h340, 8'd0);
        tick();
        idle();
        axi_wvalid = 1'b1; axi_wlast = 1'b1; axi_bvalid = 1'b1;
        tick();
        idle();
        check("W+B same cycle err_b_early", err_b_early, 0);
        check("W+B same cycle wr_burst_cnt", wr_burst_cnt, 1);
        check("W+B same cycle burst_done", burst_done, 1);
        axi_bvalid = 1'b1;
        tick();
        idle();
        check("W+B then B err_b_early", err_b_early, 1);

        // Reset in the middle of a burst.
        do_reset();
        set_aw(1'b1, 32'h400, 8'd3);
        tick();
        idle();
        axi_wvalid = 1'b1;
        tick(); tick();
        check("pre-reset outstanding", outstanding, 1);
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid reset outstanding", outstanding, 0);
        check("mid reset burst_addr", burst_addr, 0);
        check("mid reset err_any", err_any, 0);
        axi_wvalid = 1'b1; axi_wlast = 1'b0;
        tick();
        axi_wlast = 1'b1;
        tick();
        idle();
        check("leftover err_w_no_aw", err_w_no_aw, 1);
        check("leftover burst_done", burst_done, 0);
        check("leftover err_wlast", err_wlast, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
